// File: rtl/uart_rx_fifo_less.sv
// 16x-oversampling UART receiver with a single holding register (valid/ack, framing and overrun flags).
// Define UART_RX_PARITY_EN for 8E1 frames with parity_err; default build is 8N1 with parity_err tied low.
module uart_rx_fifo_less #(
  parameter int CLKSPEED = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       framing_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int DIV_RAW = CLKSPEED / (16 * BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t          state_q, state_d;
  logic            rxd_meta_q, rxs_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      samp_q, samp_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      vote_q, vote_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            perr_q, perr_d;
  logic            tick, decide, wrap, maj, load, load_perr;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_q, par_bit_d;
`endif

  assign tick   = (tick_cnt_q == TICK_MAX);
  assign decide = tick && (samp_q == 4'd9);
  assign wrap   = tick && (samp_q == 4'd15);
  // Third vote is the live synced sample at count 9.
  assign maj    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);

`ifdef UART_RX_PARITY_EN
  assign load_perr = (^shift_q) ^ par_bit_q;
`else
  assign load_perr = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    samp_d     = tick ? samp_q + 4'd1 : samp_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    vote_d     = vote_q;
    load       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
`endif

    if (tick && samp_q == 4'd7) vote_d[0] = rxs_q;
    if (tick && samp_q == 4'd8) vote_d[1] = rxs_q;

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          samp_d     = 4'd0;
          bit_idx_d  = 3'd0;
        end
      end
      S_START: begin
        if (decide && maj) state_d = S_IDLE;
        else if (wrap)     state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (wrap) begin
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (decide) par_bit_d = maj;
        if (wrap)   state_d   = S_STOP;
      end
`endif
      S_STOP: begin
        // Leave at mid-stop so a back-to-back start edge from a slightly fast sender is not missed.
        if (decide) begin
          load    = 1'b1;
          state_d = maj ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    perr_d     = perr_q;
    if (load) begin
      rx_data_d  = shift_q;
      ferr_d     = !maj;
      perr_d     = load_perr;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) ovr_d = 1'b1;
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      samp_q     <= 4'd0;
      bit_idx_q  <= 3'd0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_idx_q  <= bit_idx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      perr_q     <= perr_d;
    end
  end

  // Datapath-only state: every use is preceded by a fresh write within the frame.
  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    vote_q    <= vote_d;
`ifdef UART_RX_PARITY_EN
    par_bit_q <= par_bit_d;
`endif
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;
  assign parity_err  = perr_q;

endmodule
